// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, bit-timing helpers and line idle level.
// Macro UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } state_e;

  // Clock cycles per bit; integer division, the caller guarantees DIV >= 2.
  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 bit-period counter with synchronous clear; tick_o marks the
// last cycle of each bit period. Shared between UART transmit and receive paths.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV   = 10,
  parameter int CNT_W = cnt_width(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST) && !clr_i;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_tx_buffer_drain.sv
// Pops words from the circular buffer (one-cycle registered read) and sends them as UART
// frames. Optional even parity via UART_TX_PARITY_EN. Buffer rstb is driven with ~rst.
module uart_tx_buffer_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  buf_empty,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic                  buf_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = cnt_width(DIV);
  localparam int BIT_W = cnt_width(DATA_WIDTH);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(DIV - 2);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic             baud_clr;
  logic             baud_tick;
  logic [CNT_W-1:0] baud_cnt;

  // Bit timing runs only once the word is latched; clearing in LATCH starts the start bit at 0.
  assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LATCH);

  uart_baud_tick #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (baud_clr),
    .tick_o (baud_tick),
    .cnt_o  (baud_cnt)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (enable && !buf_empty) begin
          rd_d    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        shreg_d = buf_data;
`ifdef UART_TX_PARITY_EN
        par_d   = ^buf_data;
`endif
        tx_d    = 1'b0;
        bit_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // bit_q counts data bits already completed on the line.
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          tx_d    = LINE_IDLE;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Registered pulse lands on the final cycle of the last stop bit.
        done_d = (bit_q == LAST_STOP) && (baud_cnt == PRE_LAST);
        if (baud_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        tx_d    = LINE_IDLE;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= LINE_IDLE;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign buf_rd     = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
